// File: rtl/cache_ctrl_2way_pkg.sv
// Shared definitions for the 2-way set-associative write-back cache controller:
// address field layout, geometry and the sequencing FSM state encoding.
package cache_ctrl_2way_pkg;

    localparam int ADDR_BITS           = 10;
    localparam int DATA_BITS           = 32;
    localparam int CACHE_WORDS_PER_BLK = 4;
    localparam int CACHE_NUM_SETS      = 2;
    localparam int NUM_WAYS            = 2;

    localparam int WORD_LSB = 2;
    localparam int WORD_W   = 2;
    localparam int SET_LSB  = 4;
    localparam int SET_W    = 1;
    localparam int TAG_LSB  = 5;
    localparam int TAG_W    = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    // Word-aligned byte address of one word inside a block.
    function automatic logic [ADDR_BITS-1:0] blk_addr(
        input logic [TAG_W-1:0]  tag,
        input logic [SET_W-1:0]  set,
        input logic [WORD_W-1:0] word
    );
        return {tag, set, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Cache data storage: ways x sets x words, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module cache_data_array
    import cache_ctrl_2way_pkg::*;
#(
    parameter int DATA_W        = DATA_BITS,
    parameter int NUM_SETS      = CACHE_NUM_SETS,
    parameter int WORDS_PER_BLK = CACHE_WORDS_PER_BLK
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic              wr_way,
    input  logic [SET_W-1:0]  wr_set,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_way,
    input  logic [SET_W-1:0]  rd_set,
    input  logic [WORD_W-1:0] rd_word,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [NUM_WAYS][NUM_SETS][WORDS_PER_BLK];

    // Single synchronous write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_way][wr_set][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_way][rd_set][rd_word];

endmodule

// File: rtl/cache_ctrl_2way.sv
// Sequencing controller for a 2-way set-associative, write-back, write-allocate
// data cache: hit/miss resolution, dirty-victim write-back and block refill.
module cache_ctrl_2way
    import cache_ctrl_2way_pkg::*;
#(
    parameter int ADDR_W        = ADDR_BITS,
    parameter int DATA_W        = DATA_BITS,
    parameter int WORDS_PER_BLK = CACHE_WORDS_PER_BLK,
    parameter int NUM_SETS      = CACHE_NUM_SETS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLK - 1);

    state_t                                     state_r;
    logic                                       req_we_r;
    logic [TAG_W-1:0]                           req_tag_r;
    logic [SET_W-1:0]                           req_set_r;
    logic [WORD_W-1:0]                          req_word_r;
    logic [DATA_W-1:0]                          req_wdata_r;
    logic                                       miss_r;
    logic                                       victim_r;
    logic [WORD_W-1:0]                          cnt_r;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]          valid_r;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]          dirty_r;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tag_r;
    logic [NUM_SETS-1:0]                        lru_r;

    logic [NUM_WAYS-1:0] hit_vec_s;
    logic                hit_s;
    logic                hit_way_s;
    logic                victim_sel_s;
    logic                victim_dirty_s;
    logic                mem_fire_s;
    logic [WORD_W-1:0]   next_cnt_s;
    logic                rd_way_s;
    logic [WORD_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   arr_rdata_s;
    logic                arr_we_s;
    logic                arr_way_s;
    logic [WORD_W-1:0]   arr_word_s;
    logic [DATA_W-1:0]   arr_wdata_s;
    logic                unused_addr_s;

    assign unused_addr_s = ^cpu_addr[WORD_LSB-1:0];
    assign mem_fire_s    = mem_req && mem_ack;
    assign next_cnt_s    = cnt_r + 2'd1;

    // Tag compare in both ways of the requested set and victim choice.
    always_comb begin
        hit_vec_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[req_set_r][w] && (tag_r[req_set_r][w] == req_tag_r);
        end
        hit_s     = |hit_vec_s;
        hit_way_s = hit_vec_s[1];
        if (!valid_r[req_set_r][0]) begin
            victim_sel_s = 1'b0;
        end else if (!valid_r[req_set_r][1]) begin
            victim_sel_s = 1'b1;
        end else begin
            victim_sel_s = lru_r[req_set_r];
        end
        victim_dirty_s = valid_r[req_set_r][victim_sel_s] && dirty_r[req_set_r][victim_sel_s];
    end

    // Read port steering: hit word in LOOKUP, upcoming write-back word otherwise.
    always_comb begin
        rd_way_s  = victim_r;
        rd_word_s = cnt_r;
        case (state_r)
            LOOKUP: begin
                rd_way_s  = hit_s ? hit_way_s : victim_sel_s;
                rd_word_s = hit_s ? req_word_r : 2'd0;
            end
            WRITEBACK: begin
                rd_way_s  = victim_r;
                rd_word_s = next_cnt_s;
            end
            default: begin
                rd_way_s  = victim_r;
                rd_word_s = cnt_r;
            end
        endcase
    end

    // Write port steering: write hits and refill words.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_way_s   = victim_r;
        arr_word_s  = cnt_r;
        arr_wdata_s = mem_rdata;
        case (state_r)
            LOOKUP: begin
                if (hit_s && req_we_r) begin
                    arr_we_s    = 1'b1;
                    arr_way_s   = hit_way_s;
                    arr_word_s  = req_word_r;
                    arr_wdata_s = req_wdata_r;
                end else begin
                    arr_we_s = 1'b0;
                end
            end
            REFILL: begin
                if (mem_fire_s) begin
                    arr_we_s = 1'b1;
                end else begin
                    arr_we_s = 1'b0;
                end
            end
            default: begin
                arr_we_s = 1'b0;
            end
        endcase
    end

    cache_data_array #(
        .DATA_W        (DATA_W),
        .NUM_SETS      (NUM_SETS),
        .WORDS_PER_BLK (WORDS_PER_BLK)
    ) u_data (
        .clock   (clock),
        .wr_en   (arr_we_s),
        .wr_way  (arr_way_s),
        .wr_set  (req_set_r),
        .wr_word (arr_word_s),
        .wr_data (arr_wdata_s),
        .rd_way  (rd_way_s),
        .rd_set  (req_set_r),
        .rd_word (rd_word_s),
        .rd_data (arr_rdata_s)
    );

    // Sequencing FSM with registered CPU and memory outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            req_we_r    <= 1'b0;
            req_tag_r   <= '0;
            req_set_r   <= '0;
            req_word_r  <= '0;
            req_wdata_r <= '0;
            miss_r      <= 1'b0;
            victim_r    <= 1'b0;
            cnt_r       <= '0;
            valid_r     <= '0;
            dirty_r     <= '0;
            tag_r       <= '0;
            lru_r       <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            cpu_hit     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cpu_req) begin
                        req_we_r    <= cpu_we;
                        req_tag_r   <= cpu_addr[TAG_LSB +: TAG_W];
                        req_set_r   <= cpu_addr[SET_LSB +: SET_W];
                        req_word_r  <= cpu_addr[WORD_LSB +: WORD_W];
                        req_wdata_r <= cpu_wdata;
                        miss_r      <= 1'b0;
                        state_r     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        cpu_ready <= 1'b1;
                        cpu_hit   <= !miss_r;
                        cpu_rdata <= req_we_r ? req_wdata_r : arr_rdata_s;
                        if (req_we_r) begin
                            dirty_r[req_set_r][hit_way_s] <= 1'b1;
                        end
                        lru_r[req_set_r] <= ~hit_way_s;
                        state_r          <= IDLE;
                    end else begin
                        miss_r   <= 1'b1;
                        victim_r <= victim_sel_s;
                        cnt_r    <= '0;
                        mem_req  <= 1'b1;
                        if (victim_dirty_s) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= blk_addr(tag_r[req_set_r][victim_sel_s], req_set_r, 2'd0);
                            mem_wdata <= arr_rdata_s;
                            state_r   <= WRITEBACK;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= blk_addr(req_tag_r, req_set_r, 2'd0);
                            mem_wdata <= '0;
                            state_r   <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_fire_s) begin
                        if (cnt_r == LAST_WORD) begin
                            cnt_r                       <= '0;
                            dirty_r[req_set_r][victim_r] <= 1'b0;
                            mem_we                      <= 1'b0;
                            mem_addr                    <= blk_addr(req_tag_r, req_set_r, 2'd0);
                            mem_wdata                   <= '0;
                            state_r                     <= REFILL;
                        end else begin
                            cnt_r     <= next_cnt_s;
                            mem_addr  <= blk_addr(tag_r[req_set_r][victim_r], req_set_r, next_cnt_s);
                            mem_wdata <= arr_rdata_s;
                        end
                    end
                end
                REFILL: begin
                    if (mem_fire_s) begin
                        if (cnt_r == LAST_WORD) begin
                            cnt_r                        <= '0;
                            valid_r[req_set_r][victim_r] <= 1'b1;
                            dirty_r[req_set_r][victim_r] <= 1'b0;
                            tag_r[req_set_r][victim_r]   <= req_tag_r;
                            mem_req                      <= 1'b0;
                            state_r                      <= LOOKUP;
                        end else begin
                            cnt_r    <= next_cnt_s;
                            mem_addr <= blk_addr(req_tag_r, req_set_r, next_cnt_s);
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way with a word-wide memory model of
// programmable ack latency and a log of every memory transfer.
module tb_cache_ctrl_2way;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = 10'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
    } xact_t;

    logic [31:0] mem_model [256];
    xact_t       log_q [$];
    int          ack_lat = 0;
    int          wait_cnt = 0;
    int          stall_viol = 0;
    logic        stall_valid = 1'b0;
    logic [9:0]  stall_addr = 10'd0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [31:0] rd;
    logic        hit;
    int          cyc;
    int          spins;

    cache_ctrl_2way dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_hit   (cpu_hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_ack   = mem_req && (wait_cnt >= ack_lat);
    assign mem_rdata = mem_model[mem_addr[9:2]];

    // Memory responder: applies writes, logs transfers, watches address stability.
    always @(posedge clock) begin
        if (mem_req && mem_ack) begin
            if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
            if (stall_valid && mem_addr !== stall_addr) stall_viol <= stall_viol + 1;
            log_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
            wait_cnt    <= 0;
            stall_valid <= 1'b0;
        end else if (mem_req) begin
            if (stall_valid && mem_addr !== stall_addr) stall_viol <= stall_viol + 1;
            stall_valid <= 1'b1;
            stall_addr  <= mem_addr;
            wait_cnt    <= wait_cnt + 1;
        end else begin
            wait_cnt    <= 0;
            stall_valid <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_log(input int idx, input logic we, input logic [9:0] addr,
                             input logic [31:0] data);
        if (idx < log_q.size()) begin
            check_eq($sformatf("log%0d_we", idx), {31'd0, log_q[idx].we}, {31'd0, we});
            check_eq($sformatf("log%0d_addr", idx), {22'd0, log_q[idx].addr}, {22'd0, addr});
            check_eq($sformatf("log%0d_data", idx), log_q[idx].data, data);
        end else begin
            check_eq($sformatf("log%0d_present", idx), 32'd0, 32'd1);
        end
    endtask

    task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic hit_o, output int cycles);
        log_q.delete();
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clock);
        cpu_req = 1'b0;
        cycles  = 0;
        rdata   = 32'hDEAD_BEEF;
        hit_o   = 1'bx;
        while (cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (cpu_ready) break;
        end
        if (cpu_ready) begin
            rdata = cpu_rdata;
            hit_o = cpu_hit;
            @(negedge clock);
            check_eq("ready_pulse", {31'd0, cpu_ready}, 32'd0);
        end else begin
            check_eq("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = (i < 4) ? 32'd0 : 32'hA000_0000 + i;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_eq("rst_ctrl", {28'd0, cpu_ready, cpu_hit, mem_req, mem_we}, 32'd0);
        check_eq("rst_maddr", {22'd0, mem_addr}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);

        // Cold read miss: way 0 refilled from 0x000..0x00C.
        access(1'b0, 10'h000, 32'd0, rd, hit, cyc);
        check_eq("rd0_data", rd, 32'h0000_0000);
        check_eq("rd0_hit", {31'd0, hit}, 32'd0);
        check_eq("rd0_cyc", cyc, 32'd6);
        check_eq("rd0_nlog", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_log(i, 1'b0, 10'(i * 4), 32'd0);

        // Write hit: no memory traffic, memory untouched.
        access(1'b1, 10'h000, 32'h0000_00FF, rd, hit, cyc);
        check_eq("wr0_hit", {31'd0, hit}, 32'd1);
        check_eq("wr0_data", rd, 32'h0000_00FF);
        check_eq("wr0_nlog", log_q.size(), 32'd0);
        check_eq("wr0_mem", mem_model[0], 32'd0);

        access(1'b0, 10'h000, 32'd0, rd, hit, cyc);
        check_eq("rd1_data", rd, 32'h0000_00FF);
        check_eq("rd1_hit", {31'd0, hit}, 32'd1);
        check_eq("rd1_cyc", cyc, 32'd1);

        // 0x200 maps to set 0 as well; way 1 is still invalid.
        access(1'b0, 10'h200, 32'd0, rd, hit, cyc);
        check_eq("rd200_data", rd, 32'hA000_0080);
        check_eq("rd200_hit", {31'd0, hit}, 32'd0);
        check_eq("rd200_nlog", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_log(i, 1'b0, 10'h200 + 10'(i * 4), 32'hA000_0080 + i);

        access(1'b0, 10'h000, 32'd0, rd, hit, cyc);
        check_eq("rd2_data", rd, 32'h0000_00FF);
        check_eq("rd2_hit", {31'd0, hit}, 32'd1);

        // Slow memory: clean victim (0x200 block) replaced, no write-back.
        ack_lat = 3;
        access(1'b0, 10'h300, 32'd0, rd, hit, cyc);
        check_eq("rd300_data", rd, 32'hA000_00C0);
        check_eq("rd300_hit", {31'd0, hit}, 32'd0);
        check_eq("rd300_cyc", cyc, 32'd18);
        check_eq("rd300_nlog", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_log(i, 1'b0, 10'h300 + 10'(i * 4), 32'hA000_00C0 + i);

        // Dirty victim (0x000 block) written back before refill.
        ack_lat = 0;
        access(1'b0, 10'h200, 32'd0, rd, hit, cyc);
        check_eq("rd200b_data", rd, 32'hA000_0080);
        check_eq("rd200b_hit", {31'd0, hit}, 32'd0);
        check_eq("rd200b_cyc", cyc, 32'd10);
        check_eq("rd200b_nlog", log_q.size(), 32'd8);
        check_log(0, 1'b1, 10'h000, 32'h0000_00FF);
        for (int i = 1; i < 4; i++) check_log(i, 1'b1, 10'(i * 4), 32'd0);
        for (int i = 0; i < 4; i++) check_log(4 + i, 1'b0, 10'h200 + 10'(i * 4), 32'hA000_0080 + i);
        check_eq("wb_mem0", mem_model[0], 32'h0000_00FF);

        access(1'b0, 10'h204, 32'd0, rd, hit, cyc);
        check_eq("rd204_data", rd, 32'hA000_0081);
        check_eq("rd204_hit", {31'd0, hit}, 32'd1);

        // Reset in the middle of a slow refill of 0x100.
        ack_lat = 3;
        log_q.delete();
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h100;
        @(negedge clock);
        cpu_req = 1'b0;
        spins   = 0;
        while (log_q.size() < 2 && spins < 100) begin
            @(negedge clock);
            spins++;
        end
        check_eq("rf_progress", {31'd0, log_q.size() >= 2}, 32'd1);
        check_eq("rf_busy", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rf_rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rf_rst_rdy", {31'd0, cpu_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rf_post_req", {31'd0, mem_req}, 32'd0);

        ack_lat = 0;
        access(1'b0, 10'h100, 32'd0, rd, hit, cyc);
        check_eq("rd100_hit", {31'd0, hit}, 32'd0);
        check_eq("rd100_data", rd, 32'hA000_0040);
        check_eq("rd100_cyc", cyc, 32'd6);

        check_eq("addr_stable", stall_viol, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
# cache_ctrl_2way

Sequencing controller for the 2-way set-associative, write-back, write-allocate data cache in front of the 1 KiB byte-addressed main memory. It accepts one CPU word access at a time, resolves hit/miss against its tag/valid/dirty/LRU state, and on a miss runs a dirty-victim write-back followed by a block refill over a word-wide handshaked memory port before completing the access. It holds the cache data array and sits between the CPU-side test harness and the main memory model.

## Interface
Parameters:
- ADDR_W, 10, byte address width
- DATA_W, 32, word width
- WORDS_PER_BLK, 4, words per block (16-byte block)
- NUM_SETS, 2, sets (2 ways each, 4 blocks total)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  10  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write word
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read word (write: the written word), valid with cpu_ready
- cpu_hit  out  1  valid with cpu_ready; 1 = original lookup hit
- mem_req  out  1  memory word transfer request
- mem_we  out  1  1 = write-back word, 0 = refill read
- mem_addr  out  10  word-aligned byte address
- mem_wdata  out  32  write-back word
- mem_ack  in  1  transfer completes on any edge with mem_req && mem_ack
- mem_rdata  in  32  refill word, valid with mem_ack

## Operation
- Address split: tag = [9:5], set = [4], word = [3:2], byte = [1:0].
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE: on cpu_req, capture we/addr/wdata, clear miss flag -> LOOKUP.
- LOOKUP hit (valid && tag match, either way): read returns word; write updates word, sets dirty; LRU bit of set points to the other way; cpu_ready=1, cpu_hit = !miss flag -> IDLE.
- LOOKUP miss: set miss flag; victim = first invalid way (way 0 preferred), else LRU way; victim valid && dirty -> WRITEBACK, else -> REFILL.
- WRITEBACK: 4 words, word 0..3, mem_we=1, mem_addr = {victim tag, set, word, 2'b00}; after 4th ack clear dirty -> REFILL.
- REFILL: 4 words, mem_we=0, mem_addr = {req tag, set, word, 2'b00}; each ack writes mem_rdata into victim way; after 4th ack set valid, tag, dirty=0 -> LOOKUP (now hits; write-allocate applies the write there).
- cpu_req outside IDLE is ignored; the requester holds no state.
- Write-back only: memory is never written on a write hit.

## Timing
- Reset values: all outputs 0; FSM IDLE; all valid, dirty, LRU bits 0; word counter 0. Data array not cleared.
- Hit latency: request sampled at edge N, cpu_ready high during cycle N+1.
- Clean miss: 1 + 4·(ack latency) + 1 cycles; dirty miss adds 4·(ack latency).
- mem_req, mem_addr, mem_we, mem_wdata stable until ack; mem_req stays high across consecutive words of a burst, address advancing after each ack; deasserted in LOOKUP and IDLE.
- Counter wraps 3 -> 0 at end of each burst.
- Reset in any state: takes effect at that edge; in-flight memory burst abandoned (mem_req low next cycle), no cpu_ready, partial refill not marked valid.

## Structure
- Shared package: address field widths/positions, WORDS_PER_BLK, NUM_SETS, FSM state enum.
- One sub-module: cache_data_array (2 ways × 2 sets × 4 words, one sync write port, one async read port); tag/valid/dirty/LRU stay in the controller.

## Test plan
- Read 0x000 after reset -> miss, refill 4 reads at 0x000..0x00C, cpu_rdata=0x00000000, cpu_hit=0.
- Write 0x000 data 0x000000FF -> cpu_hit=1, no mem_req; memory[0] still 0x00.
- Read 0x000 -> cpu_hit=1, cpu_rdata=0x000000FF; read 0x200 -> miss into way 1, no write-back; read 0x000 -> hit.
- Read 0x300 -> evicts LRU way (0x200 block, clean, no write-back); read 0x200 -> miss evicts dirty 0x000 block: 4 writes at 0x000..0x00C then refill; memory[0]=0xFF.
- Memory ack latency 0 and 3 cycles both pass; mem_addr stable while mem_ack low.
- Assert reset mid-REFILL -> mem_req low next cycle, no cpu_ready; subsequent read of same address misses again.
